// File: rtl/seg7_capture_pkg.sv
// seg7_capture_pkg
// Shared definitions for the seven-segment scan capture block:
//   - active-low segment patterns {a,b,c,d,e,f,g} for hex digits 0..F
//   - active-low anode codes for digit0..digit3 and blank
//   - capture FSM state type and an anode decode helper
package seg7_capture_pkg;

    localparam logic [6:0] SEG_0 = 7'h01;
    localparam logic [6:0] SEG_1 = 7'h4F;
    localparam logic [6:0] SEG_2 = 7'h12;
    localparam logic [6:0] SEG_3 = 7'h06;
    localparam logic [6:0] SEG_4 = 7'h4C;
    localparam logic [6:0] SEG_5 = 7'h24;
    localparam logic [6:0] SEG_6 = 7'h20;
    localparam logic [6:0] SEG_7 = 7'h0F;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h04;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h60;
    localparam logic [6:0] SEG_C = 7'h31;
    localparam logic [6:0] SEG_D = 7'h42;
    localparam logic [6:0] SEG_E = 7'h30;
    localparam logic [6:0] SEG_F = 7'h38;

    localparam logic [3:0] AN_DIG0  = 4'b1110;
    localparam logic [3:0] AN_DIG1  = 4'b1101;
    localparam logic [3:0] AN_DIG2  = 4'b1011;
    localparam logic [3:0] AN_DIG3  = 4'b0111;
    localparam logic [3:0] AN_BLANK = 4'b1111;

    typedef enum logic {
        ST_WAIT,
        ST_SETTLE
    } cap_state_e;

    typedef struct packed {
        logic       legal;  // one of the four digit codes
        logic [1:0] idx;    // digit index when legal
    } an_dec_t;

    // Blank is reported as not legal here; callers test for blank first.
    function automatic an_dec_t decode_an(input logic [3:0] an);
        an_dec_t r;
        r = '{legal: 1'b1, idx: 2'd0};
        case (an)
            AN_DIG0: r.idx = 2'd0;
            AN_DIG1: r.idx = 2'd1;
            AN_DIG2: r.idx = 2'd2;
            AN_DIG3: r.idx = 2'd3;
            default: r.legal = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg7_scan_capture_if.sv
// seg7_scan_capture_if
// Valid/ready frame stream carrying one captured 4-digit display value.
//   value_o : captured frame, digit3 in [15:12] .. digit0 in [3:0]
//   valid_o : value_o holds an unconsumed frame
//   ready_i : consumer accepts on valid_o & ready_i
// master = capture block (producer), slave = consumer.
interface seg7_scan_capture_if;

    logic [15:0] value_o;
    logic        valid_o;
    logic        ready_i;

    modport master (output value_o, output valid_o, input ready_i);
    modport slave  (input value_o, input valid_o, output ready_i);

endinterface

// File: rtl/seg7_decode.sv
// seg7_decode
// Combinational decode of an active-low 7-segment pattern to a hex nibble.
//   seg_i    : segment lines {a,b,c,d,e,f,g}, active-low
//   nibble_o : decoded hex value (0 when illegal)
//   legal_o  : pattern is one of the 16 hex glyphs
module seg7_decode
    import seg7_capture_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] nibble_o,
    output logic       legal_o
);

    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        nibble_o = 4'h0;
        legal_o  = 1'b1;
        case (seg_i)
            SEG_0:   nibble_o = 4'h0;
            SEG_1:   nibble_o = 4'h1;
            SEG_2:   nibble_o = 4'h2;
            SEG_3:   nibble_o = 4'h3;
            SEG_4:   nibble_o = 4'h4;
            SEG_5:   nibble_o = 4'h5;
            SEG_6:   nibble_o = 4'h6;
            SEG_7:   nibble_o = 4'h7;
            SEG_8:   nibble_o = 4'h8;
            SEG_9:   nibble_o = 4'h9;
            SEG_A:   nibble_o = 4'hA;
            SEG_B:   nibble_o = 4'hB;
            SEG_C:   nibble_o = 4'hC;
            SEG_D:   nibble_o = 4'hD;
            SEG_E:   nibble_o = 4'hE;
            SEG_F:   nibble_o = 4'hF;
            default: legal_o  = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture
// Passive monitor on a multiplexed 4-digit seven-segment bus. Rebuilds the
// displayed hex value and publishes each complete, legal frame.
//   clk, rst : clock; asynchronous active-low reset
//   seg_i    : segment lines {a,b,c,d,e,f,g}, active-low
//   an_i     : anode lines, active-low one-hot, 1111 = blank
//   frame    : valid/ready frame stream (master side)
//   err_o    : one-cycle pulse on illegal anode code or segment pattern
//   drop_o   : one-cycle pulse when a completed frame is discarded
//   blank_o  : display judged blank
// Build option SEG7_CAPTURE_CHANGE_ONLY_EN: a completed frame equal to the
// last published value is discarded silently.
module seg7_scan_capture
    import seg7_capture_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,     // 1..255
    parameter int BLANK_CYCLES  = 1024   // 2..65535
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          seg_i,
    input  logic [3:0]          an_i,
    seg7_scan_capture_if.master frame,
    output logic                err_o,
    output logic                drop_o,
    output logic                blank_o
);

    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [15:0] BLANK_MAX   = 16'(BLANK_CYCLES);

    logic [3:0]      an_q, an_d, an_prev_q, an_prev_d;
    logic [6:0]      seg_q, seg_d;
    cap_state_e      state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [3:0]      seen_q, seen_d;
    logic [3:0][3:0] digits_q, digits_d;
    logic [15:0]     value_q, value_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic            drop_q, drop_d;
    logic            blank_q, blank_d;
    logic [15:0]     blank_cnt_q, blank_cnt_d;
`ifdef SEG7_CAPTURE_CHANGE_ONLY_EN
    logic [15:0]     last_pub_q, last_pub_d;
`endif

    an_dec_t    an_dec;
    logic [3:0] nibble;
    logic       seg_legal;
    logic       sample;
    logic       frame_done;
    logic       suppress;
    logic [3:0] seen_upd;

    seg7_decode u_decode (
        .seg_i    (seg_q),
        .nibble_o (nibble),
        .legal_o  (seg_legal)
    );

    assign an_dec = decode_an(an_q);

    always_comb begin
        an_d        = an_i;
        seg_d       = seg_i;
        an_prev_d   = an_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        seen_d      = seen_q;
        digits_d    = digits_q;
        value_d     = value_q;
        valid_d     = valid_q;
        err_d       = 1'b0;
        drop_d      = 1'b0;
        blank_d     = blank_q;
        blank_cnt_d = blank_cnt_q;
        sample      = 1'b0;
        frame_done  = 1'b0;
        suppress    = 1'b0;
        seen_upd    = seen_q;
`ifdef SEG7_CAPTURE_CHANGE_ONLY_EN
        last_pub_d  = last_pub_q;
`endif

        if (valid_q && frame.ready_i) begin
            valid_d = 1'b0;
        end

        // Consecutive blank cycles, saturating at the threshold.
        if (an_q == AN_BLANK) begin
            if (blank_cnt_q != BLANK_MAX) begin
                blank_cnt_d = blank_cnt_q + 16'd1;
            end
        end else begin
            blank_cnt_d = 16'd0;
        end

        // Capture FSM. The cycle in which a new code first shows on an_q
        // counts as settle cycle 0, so the sample lands SETTLE_CYCLES-1
        // cycles later.
        if (an_q == AN_BLANK) begin
            state_d = ST_WAIT;
            cnt_d   = 8'd0;
        end else if (!an_dec.legal) begin
            err_d   = 1'b1;
            seen_d  = 4'b0000;
            state_d = ST_WAIT;
            cnt_d   = 8'd0;
        end else if (an_q != an_prev_q) begin
            if (SETTLE_CYCLES == 1) begin
                sample = 1'b1;
            end else begin
                state_d = ST_SETTLE;
                cnt_d   = 8'd1;
            end
        end else if (state_q == ST_SETTLE) begin
            if (cnt_q == SETTLE_LAST) begin
                sample = 1'b1;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end

        if (sample) begin
            state_d = ST_WAIT;
            cnt_d   = 8'd0;
            if (!seg_legal) begin
                err_d  = 1'b1;
                seen_d = 4'b0000;
            end else begin
                blank_d              = 1'b0;
                digits_d[an_dec.idx] = nibble;
                seen_upd             = seen_q | (4'b0001 << an_dec.idx);
                if (seen_upd == 4'b1111) begin
                    frame_done = 1'b1;
                    seen_d     = 4'b0000;
                end else begin
                    seen_d = seen_upd;
                end
            end
        end

`ifdef SEG7_CAPTURE_CHANGE_ONLY_EN
        suppress = (digits_d == last_pub_q);
        if (frame_done && !suppress && !valid_q) begin
            last_pub_d = digits_d;
        end
`endif

        // A frame finishing while value_o is still owned by the consumer
        // (including the acceptance cycle itself) is dropped.
        if (frame_done && !suppress) begin
            if (valid_q) begin
                drop_d = 1'b1;
            end else begin
                value_d = digits_d;
                valid_d = 1'b1;
            end
        end

        if ((an_q == AN_BLANK) && (blank_cnt_q == BLANK_MAX - 16'd1)) begin
            blank_d = 1'b1;
            seen_d  = 4'b0000;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an_q        <= AN_BLANK;
            an_prev_q   <= AN_BLANK;
            seg_q       <= 7'h7F;
            state_q     <= ST_WAIT;
            cnt_q       <= 8'd0;
            seen_q      <= 4'b0000;
            digits_q    <= '0;
            value_q     <= 16'h0000;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            drop_q      <= 1'b0;
            blank_q     <= 1'b1;
            blank_cnt_q <= 16'd0;
`ifdef SEG7_CAPTURE_CHANGE_ONLY_EN
            last_pub_q  <= 16'h0000;
`endif
        end else begin
            an_q        <= an_d;
            an_prev_q   <= an_prev_d;
            seg_q       <= seg_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            seen_q      <= seen_d;
            digits_q    <= digits_d;
            value_q     <= value_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            drop_q      <= drop_d;
            blank_q     <= blank_d;
            blank_cnt_q <= blank_cnt_d;
`ifdef SEG7_CAPTURE_CHANGE_ONLY_EN
            last_pub_q  <= last_pub_d;
`endif
        end
    end

    assign frame.value_o = value_q;
    assign frame.valid_o = valid_q;
    assign err_o         = err_q;
    assign drop_o        = drop_q;
    assign blank_o       = blank_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb_seg7_scan_capture
// Directed bench for seg7_scan_capture. A scoreboard queue holds the frames
// the display scans should publish; a negedge monitor pops and compares them
// on every accepted transfer and counts err_o / drop_o pulses.
module tb_seg7_scan_capture;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg_i;
    logic [3:0] an_i;
    logic       err_o;
    logic       drop_o;
    logic       blank_o;

    always #5 clk = ~clk;

    seg7_scan_capture_if frame ();

    seg7_scan_capture #(
        .SETTLE_CYCLES (4),
        .BLANK_CYCLES  (1024)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .seg_i   (seg_i),
        .an_i    (an_i),
        .frame   (frame),
        .err_o   (err_o),
        .drop_o  (drop_o),
        .blank_o (blank_o)
    );

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };
    localparam logic [3:0] AN_TAB [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    int          checks   = 0;
    int          errors   = 0;
    int          err_cnt  = 0;
    int          drop_cnt = 0;
    logic [15:0] exp_q [$];
    logic [15:0] last_pub = 16'h0000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: pops one expected frame per accepted transfer.
    always @(negedge clk) begin
        if (rst) begin
            if (err_o)  err_cnt++;
            if (drop_o) drop_cnt++;
            if (frame.valid_o && frame.ready_i) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_frame: observed %0h expected none", frame.value_o);
                end
                if (exp_q.size() != 0) begin
                    check("frame_value", frame.value_o, exp_q.pop_front());
                end
            end
        end
    end

    // Predict what a completed frame does while the consumer is ready.
    task automatic exp_frame(input logic [15:0] v);
`ifdef SEG7_CAPTURE_CHANGE_ONLY_EN
        if (v == last_pub) return;
`endif
        exp_q.push_back(v);
        last_pub = v;
    endtask

    task automatic drive_digit(input int idx, input logic [3:0] nib, input int cyc);
        an_i  = AN_TAB[idx];
        seg_i = SEG_TAB[nib];
        repeat (cyc) @(posedge clk);
        #1;
    endtask

    task automatic scan(input logic [15:0] v, input int cyc);
        for (int i = 0; i < 4; i++) begin
            drive_digit(i, v[i*4 +: 4], cyc);
        end
    endtask

    int e0;
    int d0;

    initial begin
        rst           = 1'b0;
        an_i          = 4'b1111;
        seg_i         = 7'h7F;
        frame.ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_value", frame.value_o, 16'h0000);
        check("rst_valid", frame.valid_o, 1'b0);
        check("rst_err",   err_o,   1'b0);
        check("rst_drop",  drop_o,  1'b0);
        check("rst_blank", blank_o, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Two scans of 0x1A3F with a ready consumer.
        e0 = err_cnt; d0 = drop_cnt;
        exp_frame(16'h1A3F); scan(16'h1A3F, 100);
        exp_frame(16'h1A3F); scan(16'h1A3F, 100);
        check("scan_all_popped", exp_q.size(), 0);
        check("scan_no_err",  err_cnt - e0, 0);
        check("scan_no_drop", drop_cnt - d0, 0);
        check("scan_blank_cleared", blank_o, 1'b0);

        // Consumer stalled for three scans of 0x00C4.
        frame.ready_i = 1'b0;
        d0 = drop_cnt;
        exp_frame(16'h00C4);
        repeat (3) scan(16'h00C4, 100);
        check("hold_valid", frame.valid_o, 1'b1);
        check("hold_value", frame.value_o, 16'h00C4);
`ifdef SEG7_CAPTURE_CHANGE_ONLY_EN
        check("hold_drops", drop_cnt - d0, 0);
`else
        check("hold_drops", drop_cnt - d0, 2);
`endif
        frame.ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("hold_popped", exp_q.size(), 0);
        check("hold_valid_cleared", frame.valid_o, 1'b0);

        // Illegal segment pattern on digit2 mid-scan.
        e0 = err_cnt;
        drive_digit(0, 4'h4, 100);
        drive_digit(1, 4'h2, 100);
        an_i  = AN_TAB[2];
        seg_i = 7'h7F;
        repeat (100) @(posedge clk);
        #1;
        check("badseg_err_pulse", err_cnt - e0, 1);
        exp_frame(16'h1A3F); scan(16'h1A3F, 100);
        check("badseg_recover_popped", exp_q.size(), 0);
        check("badseg_single_err", err_cnt - e0, 1);

        // Illegal anode code clears the partial frame, then a long blank.
        e0 = err_cnt;
        drive_digit(0, 4'hF, 100);
        drive_digit(1, 4'hE, 100);
        an_i = 4'b1100;
        @(posedge clk);
        #1;
        drive_digit(2, 4'hE, 100);
        drive_digit(3, 4'hB, 100);
        check("badan_err_pulse", err_cnt - e0, 1);
        check("badan_blank_low", blank_o, 1'b0);
        an_i  = 4'b1111;
        seg_i = 7'h7F;
        repeat (1024) @(posedge clk);
        @(negedge clk);
        check("blank_before_threshold", blank_o, 1'b0);
        @(negedge clk);
        check("blank_at_threshold", blank_o, 1'b1);
        @(posedge clk);
        #1;
        exp_frame(16'hBEEF);
        drive_digit(0, 4'hF, 100);
        check("blank_cleared_by_sample", blank_o, 1'b0);
        drive_digit(1, 4'hE, 100);
        drive_digit(2, 4'hE, 100);
        drive_digit(3, 4'hB, 100);
        check("blank_frame_popped", exp_q.size(), 0);

        // Anode glitches shorter than the settle window are never sampled.
        e0 = err_cnt;
        drive_digit(3, 4'h9, 2);
        drive_digit(0, 4'h1, 100);
        drive_digit(1, 4'h2, 100);
        drive_digit(2, 4'h3, 100);
        drive_digit(3, 4'h7, 3);
        an_i  = 4'b1111;
        seg_i = 7'h7F;
        repeat (2) @(posedge clk);
        #1;
        exp_frame(16'h7321);
        an_i  = AN_TAB[3];
        seg_i = SEG_TAB[7];
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("settle_not_early", frame.valid_o, 1'b0);
        an_i  = 4'b1111;
        seg_i = 7'h7F;
        @(negedge clk);
        check("settle_valid_on_time", frame.valid_o, 1'b1);
        check("settle_value", frame.value_o, 16'h7321);
        @(posedge clk);
        #1;
        check("glitch_popped", exp_q.size(), 0);
        check("glitch_no_err", err_cnt - e0, 0);

        // Reset mid-frame with a pending value.
        frame.ready_i = 1'b0;
        scan(16'h5E21, 100);
        check("pre_rst_valid", frame.valid_o, 1'b1);
        drive_digit(0, 4'h1, 100);
        drive_digit(1, 4'h2, 50);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_value", frame.value_o, 16'h0000);
        check("midrst_valid", frame.valid_o, 1'b0);
        check("midrst_err",   err_o,   1'b0);
        check("midrst_drop",  drop_o,  1'b0);
        check("midrst_blank", blank_o, 1'b1);
        last_pub = 16'h0000;
        an_i  = 4'b1111;
        seg_i = 7'h7F;
        @(negedge clk);
        rst           = 1'b1;
        frame.ready_i = 1'b1;
        @(posedge clk);
        #1;
        d0 = drop_cnt;
        exp_frame(16'h5E21); scan(16'h5E21, 100);
        exp_frame(16'h5E21); scan(16'h5E21, 100);
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_popped", exp_q.size(), 0);
        check("post_rst_no_drop", drop_cnt - d0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
